apb_slave_mem: RTL and testbench

//  APB completer (slave) with local byte memory; the far end of the APB_2 bridge's pclk/presetn bus.

---
 rtl/apb_slave_pkg.sv | 14 +
 rtl/apb_slave_regfile.sv | 41 ++++
 rtl/apb_slave_mem.sv | 129 ++++++++++++
 tb/tb_apb_slave_mem.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB completer with local byte memory.
package apb_slave_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CNT_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    PERR
  } state_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port,
// and an asynchronous clear on presetn.
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Unimplemented locations read as zero so the array is never indexed out of range.
  always_comb begin
    rdata = '0;
    if ({1'b0, raddr} < DEPTH_W) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer: setup/access decode, programmable wait states, PSLVERR on out-of-range
// addresses and on bus signals that change between setup and completion.
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam logic [ADDR_WIDTH:0]  DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] WAIT_LD = CNT_WIDTH'(WAIT_CYCLES);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pwrite_q;
  logic                  capture;
  logic                  xfer_err;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      pwrite_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q   <= paddr;
        wdata_q  <= pwdata;
        pwrite_q <= pwrite;
      end
    end
  end

  // Live bus compared against the setup-phase capture; pwdata only matters for writes.
  always_comb begin
    xfer_err = ({1'b0, addr_q} >= DEPTH_W)
             | (paddr != addr_q)
             | (pwrite != pwrite_q)
             | (pwrite_q & (pwdata != wdata_q));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    pready  = 1'b0;
    pslverr = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel) begin
          if (!penable) begin
            state_d = ACCESS;
            capture = 1'b1;
            cnt_d   = WAIT_LD;
          end else begin
            state_d = PERR;
          end
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          if (penable) begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          pready  = 1'b1;
          pslverr = xfer_err;
          if (penable) begin
            mem_we  = pwrite_q & ~xfer_err;
            state_d = IDLE;
          end
        end
      end
      PERR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    prdata = '0;
    if ((state_q == ACCESS) && pready && !pwrite_q && !pslverr) begin
      prdata = rd_data;
    end
  end

  apb_slave_regfile #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .pclk    (pclk),
    .presetn (presetn),
    .we      (mem_we),
    .waddr   (addr_q),
    .wdata   (wdata_q),
    .raddr   (addr_q),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: four instances with different wait/depth settings, a vector
// table, hand-written corner sequences and randomized transfers against a memory model.
module tb_apb_slave_mem;

  localparam int unsigned NI = 4;
  localparam int unsigned W0 = 0, W1 = 3, W2 = 0, W3 = 2;
  localparam int unsigned D0 = 256, D1 = 256, D2 = 192, D3 = 256;

  int unsigned waits  [NI] = '{W0, W1, W2, W3};
  int unsigned depths [NI] = '{D0, D1, D2, D3};

  logic          pclk    = 1'b0;
  logic          presetn = 1'b0;
  logic [NI-1:0] psel    = '0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [7:0]    paddr   = '0;
  logic [7:0]    pwdata  = '0;
  logic [7:0]    prdata_v [NI];
  logic [NI-1:0] pready_v;
  logic [NI-1:0] pslverr_v;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mdl [NI][256];

  typedef struct {
    int         k;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         corrupt;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;

  vec_t vt[$];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(D0), .WAIT_CYCLES(W0)) u0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(D1), .WAIT_CYCLES(W1)) u1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(D2), .WAIT_CYCLES(W2)) u2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(D3), .WAIT_CYCLES(W3)) u3 (
    .pclk(pclk), .presetn(presetn), .psel(psel[3]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[3]), .pready(pready_v[3]),
    .pslverr(pslverr_v[3]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Reference model: an access errors when out of range or when the master changed
  // the address (or the write data of a write) after the setup phase.
  function automatic bit m_err(input int k, input bit wr, input logic [7:0] addr,
                               input int corrupt);
    return (int'(addr) >= int'(depths[k])) || (corrupt == 1) || (corrupt == 2 && wr);
  endfunction

  function automatic logic [7:0] m_rd(input int k, input bit wr, input logic [7:0] addr,
                                      input int corrupt);
    if (wr || m_err(k, wr, addr, corrupt)) return 8'h00;
    return mdl[k][addr];
  endfunction

  task automatic m_commit(input int k, input bit wr, input logic [7:0] addr,
                          input logic [7:0] data, input int corrupt);
    if (wr && !m_err(k, wr, addr, corrupt)) mdl[k][addr] = data;
  endtask

  task automatic m_clear();
    for (int k = 0; k < int'(NI); k++)
      for (int a = 0; a < 256; a++) mdl[k][a] = 8'h00;
  endtask

  // One APB transfer on instance k; corrupt=1 alters paddr, corrupt=2 alters pwdata
  // in the access phase. Counts PREADY-low access cycles and checks them.
  task automatic xfer(input int k, input bit wr, input logic [7:0] addr,
                      input logic [7:0] data, input int corrupt, input string tag,
                      output logic [7:0] rd, output logic err);
    int cyc;
    bit done;
    psel    = '0;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    step();
    penable = 1'b1;
    if (corrupt == 1) paddr = addr ^ 8'h04;
    else if (corrupt == 2) pwdata = ~data;
    cyc  = 0;
    done = 1'b0;
    rd   = 8'h00;
    err  = 1'b1;
    while (!done) begin
      @(negedge pclk);
      if (pready_v[k]) begin
        rd   = prdata_v[k];
        err  = pslverr_v[k];
        done = 1'b1;
      end else if (cyc >= 40) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s timeout: actual=no pready required=pready within 40 cycles", tag);
        done = 1'b1;
      end else begin
        cyc++;
      end
      @(posedge pclk);
      #1;
    end
    psel    = '0;
    penable = 1'b0;
    chk({tag, " waits"}, 32'(cyc), 32'(waits[k]));
  endtask

  task automatic run_chk(input int k, input bit wr, input logic [7:0] addr,
                         input logic [7:0] data, input int corrupt, input string tag,
                         input logic [7:0] exp_rd, input bit exp_err);
    logic [7:0] rd;
    logic       err;
    xfer(k, wr, addr, data, corrupt, tag, rd, err);
    chk({tag, " prdata"}, 32'(rd), 32'(exp_rd));
    chk({tag, " pslverr"}, 32'(err), 32'(exp_err));
    m_commit(k, wr, addr, data, corrupt);
  endtask

  initial begin
    m_clear();
    //                k  wr addr   data   cor rd     err
    vt.push_back('{0, 1, 8'h10, 8'h5A, 0, 8'h00, 1'b0});
    vt.push_back('{0, 0, 8'h10, 8'h00, 0, 8'h5A, 1'b0});
    vt.push_back('{1, 1, 8'h10, 8'h5A, 0, 8'h00, 1'b0});
    vt.push_back('{1, 0, 8'h10, 8'h00, 0, 8'h5A, 1'b0});
    vt.push_back('{2, 1, 8'hC0, 8'hFF, 0, 8'h00, 1'b1});
    vt.push_back('{2, 0, 8'hC0, 8'h00, 0, 8'h00, 1'b1});
    vt.push_back('{2, 0, 8'hBF, 8'h00, 0, 8'h00, 1'b0});
    vt.push_back('{2, 1, 8'hBF, 8'h3C, 0, 8'h00, 1'b0});
    vt.push_back('{2, 0, 8'hBF, 8'h00, 0, 8'h3C, 1'b0});
    vt.push_back('{2, 0, 8'h00, 8'h00, 0, 8'h00, 1'b0});
    vt.push_back('{0, 1, 8'hFF, 8'hA5, 0, 8'h00, 1'b0});
    vt.push_back('{0, 0, 8'hFF, 8'h00, 0, 8'hA5, 1'b0});
    vt.push_back('{0, 1, 8'h20, 8'h11, 2, 8'h00, 1'b1});
    vt.push_back('{0, 0, 8'h20, 8'h00, 0, 8'h00, 1'b0});
    vt.push_back('{0, 0, 8'h10, 8'h77, 2, 8'h5A, 1'b0});
    vt.push_back('{0, 0, 8'h10, 8'h00, 1, 8'h00, 1'b1});
    vt.push_back('{0, 1, 8'h30, 8'h66, 1, 8'h00, 1'b1});
    vt.push_back('{0, 0, 8'h30, 8'h00, 0, 8'h00, 1'b0});
    vt.push_back('{3, 1, 8'h40, 8'hC3, 0, 8'h00, 1'b0});
    vt.push_back('{3, 0, 8'h40, 8'h00, 0, 8'hC3, 1'b0});

    #2;
    for (int k = 0; k < int'(NI); k++) begin
      chk($sformatf("reset pready[%0d]", k), 32'(pready_v[k]), 32'h0);
      chk($sformatf("reset pslverr[%0d]", k), 32'(pslverr_v[k]), 32'h0);
      chk($sformatf("reset prdata[%0d]", k), 32'(prdata_v[k]), 32'h0);
    end
    @(posedge pclk);
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    step();

    foreach (vt[i]) begin
      run_chk(vt[i].k, vt[i].wr, vt[i].addr, vt[i].data, vt[i].corrupt,
              $sformatf("vec%0d", i), vt[i].exp_rd, vt[i].exp_err);
    end

    // Access phase without setup phase: one-cycle error response.
    psel    = '0;
    psel[0] = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    @(negedge pclk);
    chk("perr idle pready", 32'(pready_v[0]), 32'h0);
    step();
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    chk("perr pready", 32'(pready_v[0]), 32'h1);
    chk("perr pslverr", 32'(pslverr_v[0]), 32'h1);
    chk("perr prdata", 32'(prdata_v[0]), 32'h0);
    step();
    @(negedge pclk);
    chk("perr after pready", 32'(pready_v[0]), 32'h0);
    chk("perr after pslverr", 32'(pslverr_v[0]), 32'h0);
    step();
    run_chk(0, 1'b0, 8'h00, 8'h00, 0, "perr read0", 8'h00, 1'b0);

    // Master abort during wait states on the WAIT_CYCLES=2 instance.
    run_chk(3, 1'b1, 8'h20, 8'h44, 0, "abort prior", 8'h00, 1'b0);
    psel    = '0;
    psel[3] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h20;
    pwdata  = 8'h33;
    step();
    penable = 1'b1;
    @(negedge pclk);
    chk("abort wait pready", 32'(pready_v[3]), 32'h0);
    step();
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    chk("abort pready", 32'(pready_v[3]), 32'h0);
    chk("abort pslverr", 32'(pslverr_v[3]), 32'h0);
    step();
    run_chk(3, 1'b0, 8'h20, 8'h00, 0, "abort read", 8'h44, 1'b0);

    // Reset in the middle of a write access.
    run_chk(0, 1'b1, 8'h01, 8'h77, 0, "rst write", 8'h00, 1'b0);
    run_chk(0, 1'b0, 8'h01, 8'h00, 0, "rst pre read", 8'h77, 1'b0);
    psel    = '0;
    psel[0] = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h01;
    pwdata  = 8'h99;
    step();
    penable = 1'b1;
    @(negedge pclk);
    chk("rst access pready", 32'(pready_v[0]), 32'h1);
    #1;
    presetn = 1'b0;
    #1;
    chk("rst pready", 32'(pready_v[0]), 32'h0);
    chk("rst pslverr", 32'(pslverr_v[0]), 32'h0);
    chk("rst prdata", 32'(prdata_v[0]), 32'h0);
    psel    = '0;
    penable = 1'b0;
    step();
    step();
    presetn = 1'b1;
    m_clear();
    step();
    run_chk(0, 1'b0, 8'h01, 8'h00, 0, "rst read", 8'h00, 1'b0);
    run_chk(1, 1'b0, 8'h10, 8'h00, 0, "rst read u1", 8'h00, 1'b0);

    // Randomized traffic against the memory model.
    for (int i = 0; i < 300; i++) begin
      int         k;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] data;
      int         cor;
      k  = int'($urandom_range(0, NI - 1));
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       addr = 8'($urandom_range(0, 255));
        1:       addr = 8'($urandom_range(0, 7));
        2:       addr = 8'($urandom_range(188, 195));
        default: addr = 8'($urandom_range(248, 255));
      endcase
      data = 8'($urandom);
      cor  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_chk(k, wr, addr, data, cor, $sformatf("rnd%0d", i),
              m_rd(k, wr, addr, cor), m_err(k, wr, addr, cor));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
